// File: rtl/frame_pkg.sv
// Shared definitions for the FIFO frame writer: state encoding, header sync byte,
// write-word byte placement and default image geometry.
package frame_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam int PIX_LSB = 2;
  localparam int PIX_MSB = 9;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_HDR    = 2'd1,
    FS_STREAM = 2'd2,
    FS_DROP   = 2'd3
  } frame_state_e;

  localparam logic [1:0] ST_IDLE   = FS_IDLE;
  localparam logic [1:0] ST_HDR    = FS_HDR;
  localparam logic [1:0] ST_STREAM = FS_STREAM;
  localparam logic [1:0] ST_DROP   = FS_DROP;

  // Places a byte into the 32-bit FIFO word; every other bit stays zero.
  function automatic logic [31:0] pack_byte(input logic [7:0] b);
    logic [31:0] w;
    w = '0;
    w[PIX_MSB:PIX_LSB] = b;
    return w;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Loadable pixel up-counter; o_tc flags the increment that completes an N-pixel frame.
module frame_pixel_counter #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = i_inc && (r_count == W'(N - 1));

endmodule

// File: rtl/fifo_frame_writer.sv
// Gates whole pixel frames on host readiness and drives the FIFO write port.
// Optional two-word frame header is enabled by defining FRAME_HEADER_EN.
module fifo_frame_writer
  import frame_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int N    = IMG_W * IMG_H,
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  input  logic          USB_ready,
  input  logic          FIFO_full,
  output logic          FIFO_wr_enable,
  output logic [31:0]   FIFO_data_in,
  output logic [15:0]   frame_count,
  output logic          overflow,
  output logic          short_frame,
  output logic          busy,
  output logic [1:0]    o_dbg_state,
  output logic [CW-1:0] o_dbg_pix_count
);

  // Handshake: a word is handed to the FIFO on every cycle FIFO_wr_enable is 1;
  // there is no backpressure beyond FIFO_full, sampled alongside pix_valid.

  logic [1:0]  r_state;
  logic        r_wr_en;
  logic [31:0] r_data;
  logic [15:0] r_frame_count;
  logic        r_overflow;
  logic        r_short;

  logic [1:0]  w_next_state;
  logic        w_wr;
  logic [31:0] w_wr_data;
  logic        w_clear;
  logic        w_inc;
  logic        w_tc;
  logic        w_set_ovf;
  logic        w_set_short;
  logic        w_frame_done;
  logic        w_sof_take;

  frame_pixel_counter #(.N(N), .W(CW)) u_pix_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_count (o_dbg_pix_count),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next_state = r_state;
    w_wr         = 1'b0;
    w_wr_data    = r_data;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_short  = 1'b0;
    w_frame_done = 1'b0;
    w_sof_take   = 1'b0;

    case (r_state)
      ST_IDLE, ST_DROP: begin
        if (sof) w_sof_take = 1'b1;
      end
      ST_HDR: begin
        if (sof) begin
          w_set_short = 1'b1;
          w_sof_take  = 1'b1;
        end else begin
          w_wr         = 1'b1;
          w_wr_data    = pack_byte(r_frame_count[7:0]);
          w_next_state = ST_STREAM;
          if (pix_valid) w_set_short = 1'b1;
        end
      end
      ST_STREAM: begin
        // sof wins over a coincident pixel, which is discarded.
        if (sof) begin
          w_set_short = 1'b1;
          w_sof_take  = 1'b1;
        end else if (pix_valid) begin
          if (FIFO_full) begin
            w_set_ovf    = 1'b1;
            w_next_state = ST_DROP;
          end else begin
            w_wr      = 1'b1;
            w_wr_data = pack_byte(pix_data);
            w_inc     = 1'b1;
            if (w_tc) begin
              w_frame_done = 1'b1;
              w_next_state = ST_IDLE;
            end
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    if (w_sof_take) begin
      w_clear = 1'b1;
      if (USB_ready) begin
`ifdef FRAME_HEADER_EN
        w_next_state = ST_HDR;
        w_wr         = 1'b1;
        w_wr_data    = pack_byte(HDR_SYNC);
`else
        w_next_state = ST_STREAM;
`endif
      end else begin
        w_next_state = ST_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wr_en       <= 1'b0;
      r_data        <= '0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
      r_short       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wr_en <= w_wr;
      r_data  <= w_wr_data;
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      if (w_set_ovf)    r_overflow    <= 1'b1;
      if (w_set_short)  r_short       <= 1'b1;
    end
  end

  assign FIFO_wr_enable = r_wr_en;
  assign FIFO_data_in   = r_data;
  assign frame_count    = r_frame_count;
  assign overflow       = r_overflow;
  assign short_frame    = r_short;
  assign busy           = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;

endmodule
